// File: rtl/carry_chain_sched.sv
// Two-requester scheduler for one time-shared SEG-bit majority-carry ripple segment.
// Operands are consumed SEG bits per cycle; the result returns with its requester tag.
module carry_chain_sched #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    localparam int NSEG = WIDTH / SEG;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_id;
    logic             r_prio;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_sel;
    logic [BW-1:0]    w_base;
    logic [SEG-1:0]   w_seg_a;
    logic [SEG-1:0]   w_seg_b;
    logic [SEG-1:0]   w_seg_s;
    logic [SEG:0]     w_c;
    logic [WIDTH-1:0] w_acc_nxt;

    assign res_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign res_id    = r_id;

    // The carry segment: majority-gate ripple over the current SEG-bit slice.
    always_comb begin
        w_base    = BW'(r_cnt * SEG);
        w_seg_a   = r_a[w_base +: SEG];
        w_seg_b   = r_b[w_base +: SEG];
        w_seg_s   = '0;
        w_c       = '0;
        w_c[0]    = r_carry;
        for (int unsigned i = 0; i < SEG; i++) begin
            w_c[i+1]   = (w_seg_a[i] & w_seg_b[i]) | (w_seg_a[i] & w_c[i]) | (w_seg_b[i] & w_c[i]);
            w_seg_s[i] = w_seg_a[i] ^ w_seg_b[i] ^ w_c[i];
        end
        w_acc_nxt                 = r_acc;
        w_acc_nxt[w_base +: SEG]  = w_seg_s;
    end

    // Exactly one ready in IDLE: the priority holder unless it is idle and the other is not.
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_sel       = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_prio == 1'b0) begin
                    req0_ready = req0_valid | ~req1_valid;
                    req1_ready = ~req0_ready;
                end else begin
                    req1_ready = req1_valid | ~req0_valid;
                    req0_ready = ~req1_ready;
                end
                w_sel    = req1_ready;
                w_accept = w_sel ? req1_valid : req0_valid;
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Partial sums build in r_acc so res_sum only changes when a result completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel ? req1_a : req0_a;
                        r_b     <= w_sel ? req1_b : req0_b;
                        r_carry <= w_sel ? req1_cin : req0_cin;
                        r_id    <= w_sel;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_c[SEG];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum  <= w_acc_nxt;
                        r_cout <= w_c[SEG];
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_prio <= ~r_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carry_chain_sched.sv
// Scoreboard bench for carry_chain_sched: accepted operations are modelled with a plain
// wide add and queued; each result handshake pops and compares sum, carry and tag.
`timescale 1ns/1ps
module tb_carry_chain_sched;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSEG  = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req0_cin = 1'b0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             req1_cin = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             id;
    } exp_t;

    exp_t q[$];
    int   nerr = 0;
    int   ncheck = 0;
    int   cyc = 0;
    logic exp_prio = 1'b0;

    carry_chain_sched #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic id);
        logic [WIDTH:0] t;
        exp_t e;
        t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.id   = id;
        return e;
    endfunction

    // Called at a negedge with inputs set: records accepts, then advances to the next negedge.
    task automatic tick();
        #1;
        if (req0_valid && req0_ready) q.push_back(model(req0_a, req0_b, req0_cin, 1'b0));
        if (req1_valid && req1_ready) q.push_back(model(req1_a, req1_b, req1_cin, 1'b1));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (q.size() > 0);
        if (ok) begin
            e = q.pop_front();
            exp_prio = ~e.id;
        end else begin
            e = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        ncheck++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        ncheck++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        ncheck++; if (res_sum !== '0) begin nerr++; $display("FAIL reset_sum: got %h want 0", res_sum); end
        ncheck++; if ({res_cout, res_id} !== 2'b00) begin nerr++; $display("FAIL reset_cout_id: got %b want 00", {res_cout, res_id}); end
        ncheck++; if ({req0_ready, req1_ready} !== 2'b10) begin nerr++; $display("FAIL reset_ready: got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_prio = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_t e;
        bit   ok;
        req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0; res_ready = 1'b0;
        #1;
        ncheck++; if ({req0_ready, req1_ready} !== 2'b10) begin nerr++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            #1;
            ncheck++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy_run: got %b want 1 at k=%0d", busy, k); end
            ncheck++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL single_latency: res_valid got %b want 0 at k=%0d", res_valid, k); end
            ncheck++; if ({req0_ready, req1_ready} !== 2'b00) begin nerr++; $display("FAIL single_ready_run: got %b want 00", {req0_ready, req1_ready}); end
            tick();
        end
        #1;
        ncheck++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL single_valid: got %b want 1", res_valid); end
        ncheck++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy_done: got %b want 1", busy); end
        ncheck++; if (res_sum !== 16'h0100) begin nerr++; $display("FAIL single_sum: got %h want 0100", res_sum); end
        ncheck++; if ({res_cout, res_id} !== 2'b00) begin nerr++; $display("FAIL single_cout_id: got %b want 00", {res_cout, res_id}); end
        res_ready = 1'b1;
        pop_exp(e, ok);
        ncheck++; if (!ok || res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
            nerr++; $display("FAIL single_sb: got %h/%b/%b want %h/%b/%b ok=%0d", res_sum, res_cout, res_id, e.sum, e.cout, e.id, ok);
        end
        tick();
        res_ready = 1'b0;
        #1;
        ncheck++; if ({res_valid, busy} !== 2'b00) begin nerr++; $display("FAIL single_after_hs: got %b want 00", {res_valid, busy}); end
        ncheck++; if (res_sum !== 16'h0100) begin nerr++; $display("FAIL single_sum_hold: got %h want 0100", res_sum); end
        tick();
    endtask

    task automatic test_propagate();
        logic [WIDTH-1:0] ta [2] = '{16'h8000, 16'hFFFF};
        logic [WIDTH-1:0] tb [2] = '{16'h8000, 16'h0000};
        logic             tc [2] = '{1'b0, 1'b1};
        logic             tid[2] = '{1'b0, 1'b1};
        exp_t e;
        bit   ok;
        int   n;
        for (int t = 0; t < 2; t++) begin
            if (tid[t]) begin
                req1_a = ta[t]; req1_b = tb[t]; req1_cin = tc[t]; req1_valid = 1'b1;
            end else begin
                req0_a = ta[t]; req0_b = tb[t]; req0_cin = tc[t]; req0_valid = 1'b1;
            end
            res_ready = 1'b1;
            #1;
            ncheck++; if ((tid[t] ? req1_ready : req0_ready) !== 1'b1) begin nerr++; $display("FAIL prop_ready%0d: got 0 want 1", t); end
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            n = 0;
            while (!res_valid && n < 20) begin tick(); n++; end
            #1;
            ncheck++; if (n !== NSEG) begin nerr++; $display("FAIL prop_latency%0d: got %0d want %0d", t, n, NSEG); end
            ncheck++; if (res_sum !== 16'h0000 || res_cout !== 1'b1 || res_id !== tid[t]) begin
                nerr++; $display("FAIL prop_result%0d: got %h/%b/%b want 0000/1/%b", t, res_sum, res_cout, res_id, tid[t]);
            end
            pop_exp(e, ok);
            ncheck++; if (!ok || res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
                nerr++; $display("FAIL prop_sb%0d: got %h/%b/%b want %h/%b/%b", t, res_sum, res_cout, res_id, e.sum, e.cout, e.id);
            end
            tick();
        end
        res_ready = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        exp_t e;
        bit   ok;
        int   got = 0;
        int   n = 0;
        int   last_acc = -1;
        logic want = exp_prio;
        logic who;
        logic idle;
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom);
        req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom);
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        while (got < 4 && n < 80) begin
            #1;
            idle = ~busy;
            ncheck++; if (busy ? (req0_ready | req1_ready) : (req0_ready == req1_ready)) begin
                nerr++; $display("FAIL cont_ready_excl: got %b want %s", {req0_ready, req1_ready}, busy ? "00" : "one-hot");
            end
            who = req1_ready;
            if (idle) begin
                ncheck++; if (who !== want) begin nerr++; $display("FAIL cont_grant: got %b want %b", who, want); end
                if (last_acc >= 0) begin
                    ncheck++; if (cyc - last_acc !== NSEG + 2) begin nerr++; $display("FAIL cont_period: got %0d want %0d", cyc - last_acc, NSEG + 2); end
                end
                last_acc = cyc;
            end
            if (res_valid && res_ready) begin
                pop_exp(e, ok);
                ncheck++; if (!ok || res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id || res_id !== want) begin
                    nerr++; $display("FAIL cont_sb: got %h/%b/%b want %h/%b/%b", res_sum, res_cout, res_id, e.sum, e.cout, want);
                end
                want = ~want;
                got++;
            end
            tick();
            n++;
            if (idle) begin
                if (who) begin req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom); end
                else     begin req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom); end
            end
        end
        ncheck++; if (got !== 4) begin nerr++; $display("FAIL cont_count: got %0d want 4", got); end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        int   n = 0;
        req0_a = 16'h1357; req0_b = 16'h2468; req0_cin = 1'b1;
        req1_a = 16'hABCD; req1_b = 16'h1111; req1_cin = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        while (!res_valid && n < 20) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            #1;
            ncheck++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid%0d: got %b want 1", k, res_valid); end
            ncheck++; if (q.size() == 0 || res_sum !== q[0].sum || res_id !== q[0].id) begin
                nerr++; $display("FAIL bp_stable%0d: got %h/%b queue=%0d", k, res_sum, res_id, q.size());
            end
            ncheck++; if ({req0_ready, req1_ready} !== 2'b00) begin nerr++; $display("FAIL bp_ready%0d: got %b want 00", k, {req0_ready, req1_ready}); end
            tick();
        end
        res_ready = 1'b1;
        #1;
        pop_exp(e, ok);
        ncheck++; if (!ok || res_valid !== 1'b1 || res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
            nerr++; $display("FAIL bp_sb: got %b/%h/%b/%b want 1/%h/%b/%b", res_valid, res_sum, res_cout, res_id, e.sum, e.cout, e.id);
        end
        tick();
        #1;
        ncheck++; if ({res_valid, busy} !== 2'b00) begin nerr++; $display("FAIL bp_one_hs: got %b want 00", {res_valid, busy}); end
        ncheck++; if ({req0_ready, req1_ready} !== {~exp_prio, exp_prio}) begin
            nerr++; $display("FAIL bp_next_ready: got %b want %b", {req0_ready, req1_ready}, {~exp_prio, exp_prio});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        ncheck++; if (busy !== 1'b1) begin nerr++; $display("FAIL bp_next_accept: busy got %b want 1", busy); end
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        #1;
        pop_exp(e, ok);
        ncheck++; if (!ok || res_valid !== 1'b1 || res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
            nerr++; $display("FAIL bp_sb2: got %b/%h/%b/%b want 1/%h/%b/%b", res_valid, res_sum, res_cout, res_id, e.sum, e.cout, e.id);
        end
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        int   n = 0;
        int   seen = 0;
        req1_a = 16'h0F0F; req1_b = 16'h1111; req1_cin = 1'b1; req1_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        ncheck++; if ({res_valid, busy} !== 2'b00) begin nerr++; $display("FAIL rst_mid_state: got %b want 00", {res_valid, busy}); end
        ncheck++; if (res_sum !== '0 || {res_cout, res_id} !== 2'b00) begin
            nerr++; $display("FAIL rst_mid_outs: got %h/%b/%b want 0000/0/0", res_sum, res_cout, res_id);
        end
        ncheck++; if ({req0_ready, req1_ready} !== 2'b10) begin nerr++; $display("FAIL rst_mid_ready: got %b want 10", {req0_ready, req1_ready}); end
        q.delete();
        exp_prio = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (res_valid) seen++;
            tick();
        end
        ncheck++; if (seen !== 0) begin nerr++; $display("FAIL rst_mid_no_result: got %0d want 0", seen); end
        req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        while (!res_valid && n < 20) begin tick(); n++; end
        #1;
        ncheck++; if (res_valid !== 1'b1 || res_sum !== 16'h5555 || res_cout !== 1'b0 || res_id !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_next: got %b/%h/%b/%b want 1/5555/0/0", res_valid, res_sum, res_cout, res_id);
        end
        pop_exp(e, ok);
        ncheck++; if (!ok || q.size() != 0 || res_sum !== e.sum) begin
            nerr++; $display("FAIL rst_mid_sb: got %h want %h ok=%0d left=%0d", res_sum, e.sum, ok, q.size());
        end
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        bit   ok;
        int   done = 0;
        int   n = 0;
        while (done < 1000 && n < 30000) begin
            req0_valid = 1'($urandom); req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom);
            req1_valid = 1'($urandom); req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            ncheck++; if (busy ? (req0_ready | req1_ready) : (req0_ready == req1_ready)) begin
                nerr++; $display("FAIL rnd_ready_excl: got %b busy=%b", {req0_ready, req1_ready}, busy);
            end
            if (res_valid && res_ready) begin
                pop_exp(e, ok);
                ncheck++; if (!ok || q.size() != 0) begin nerr++; $display("FAIL rnd_order: ok=%0d left=%0d want 1/0", ok, q.size()); end
                ncheck++; if (res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
                    nerr++; $display("FAIL rnd_result: got %h/%b/%b want %h/%b/%b", res_sum, res_cout, res_id, e.sum, e.cout, e.id);
                end
                done++;
            end
            tick();
            n++;
        end
        ncheck++; if (done !== 1000) begin nerr++; $display("FAIL rnd_count: got %0d want 1000", done); end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_propagate();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

    initial begin
        #2000000;
        nerr++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $fatal(1);
    end

endmodule

// File: doc/carry_chain_sched.md
Name: carry_chain_sched

Overview:
- Time-shared controller for one majority-gate carry-ripple segment: MAJ(a,b,c) carry, XOR sum.
- Two requesters submit WIDTH-bit add operations. A round-robin arbiter grants one. The controller then sequences the operands through the SEG-bit segment over WIDTH/SEG cycles, keeping the running carry in a register.
- Result is returned on a valid/ready output with requester tag.
- Sits between operand producers and the shared carry-chain datapath; the carry chain itself is instantiated inside as combinational logic.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- SEG, 4, bits processed per cycle. WIDTH must be a multiple of SEG; NSEG = WIDTH/SEG.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  A+B+cin modulo 2^WIDTH.
- res_cout  out  1  carry out of bit WIDTH-1.
- res_id  out  1  index of the requester that issued the result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset is asynchronous: state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, seg counter=0, carry reg=0, priority=req0. A reset mid-operation aborts it and no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE, ready rule: exactly one reqX_ready is high, combinationally.
  - The priority holder gets ready if it is valid or the other requester is not valid.
  - Otherwise the other requester gets ready.
  - Both readys are low in RUN and DONE.
- IDLE, accept (valid&ready of the readied requester at a clock edge):
  - Capture a and b into operand regs, carry reg<=cin, res_id<=X, counter<=0.
  - Go to RUN.
  - Inputs are not sampled after capture.
- RUN, each cycle k=counter:
  - Ripple segment bits [k*SEG +: SEG]: c(i+1)=MAJ(a_i,b_i,c_i), s_i=a_i^b_i^c_i, with c at the segment base = carry reg.
  - Write the sum bits into the sum reg; carry reg<=segment carry out; counter<=k+1.
  - When k==NSEG-1: res_cout<=segment carry out, go to DONE.
- Latency: res_valid rises exactly NSEG clock edges after the accept edge (4 for defaults).
- DONE:
  - res_valid=1. res_sum, res_cout and res_id are held stable until res_valid&res_ready at an edge.
  - On that edge: go to IDLE, res_valid<=0, priority<=the requester not just served.
- Ordering and throughput:
  - No new request is accepted in the same cycle as the result handshake; the next accept occurs in IDLE at the earliest one cycle later.
  - Minimum period is NSEG+2 cycles per operation.
- res_sum and res_cout are registered outputs. They retain their last value after handshake until the next completion.
- Sum register bits not yet written during RUN hold stale data; they are not observable because res_valid=0.
- Continuous contention: grants alternate 0,1,0,1,...
- A single requester alone is served back-to-back with no idle gaps beyond the IDLE accept cycle.
- A requester dropping valid while not ready is legal; nothing is captured.

Test Plan:
- Single op: req0 a=0x00FF, b=0x0001, cin=0, others idle → req0_ready=1 in IDLE; after 4 edges res_valid=1, res_sum=0x0100, res_cout=0, res_id=0; busy=1 throughout RUN and DONE.
- Full propagate across segments: req1 a=0xFFFF, b=0x0000, cin=1 → res_sum=0x0000, res_cout=1, res_id=1. Also a=0x8000, b=0x8000, cin=0 → res_sum=0x0000, res_cout=1.
- Contention: both valid continuously, res_ready=1, four ops → res_id sequence 0,1,0,1; each accept is separated by 6 cycles; the non-granted ready stays 0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid, res_sum and res_id are stable; req0_ready and req1_ready stay 0 with both valid; after res_ready=1, exactly one handshake occurs and the next accept follows one cycle later.
- Reset mid-RUN: assert rst_n=0 at counter=2, release → all outputs at reset values immediately with no clock edge needed, no res_valid pulse, next op 0x1234+0x4321 cin=0 → 0x5555, res_cout=0.
- Random: 1000 ops with random operands, cin, valids and res_ready → sum and cout match the reference add; tags match the issuing requester; no op is lost or duplicated.
